// File: rtl/wb_cmd_master.sv
// Host byte-stream to Wishbone bridge: parses [op][adr_hi][adr_lo][cnt][data..] frames,
// issues single transfers with an auto-incrementing address and returns read data plus a status byte.
module wb_cmd_master #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [15:0] wb_adr_o,
   output logic [7:0]  wb_dat_o,
   input  logic [7:0]  wb_dat_i,
   input  logic        wb_ack_i
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADRH, S_ADRL, S_CNT, S_WDATA,
      S_WBUS, S_RBUS, S_RSEND, S_DRAIN, S_STATUS
   } state_t;

   localparam logic [7:0]  OP_WR     = 8'h01;
   localparam logic [7:0]  OP_RD     = 8'h02;
   localparam logic [7:0]  ST_OK     = 8'h00;
   localparam logic [7:0]  ST_TMO    = 8'h01;
   localparam logic [7:0]  ST_BADOP  = 8'h02;
   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

   state_t      state;
   logic        is_wr;
   logic [8:0]  cnt;
   logic [15:0] timer;

   logic in_fire;
   logic out_fire;
   logic bus_ack;
   logic bus_tmo;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign bus_ack  = wb_stb_o & wb_ack_i;
   assign bus_tmo  = wb_stb_o & ~wb_ack_i & (timer == TMO_LAST);

   // A count byte of zero encodes a full 256-transfer burst.
   function automatic logic [8:0] decode_cnt(input logic [7:0] b);
      return (b == 8'h00) ? 9'd256 : {1'b0, b};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         is_wr     <= 1'b0;
         cnt       <= '0;
         timer     <= '0;
         in_ready  <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         wb_cyc_o  <= 1'b0;
         wb_stb_o  <= 1'b0;
         wb_we_o   <= 1'b0;
         wb_adr_o  <= '0;
         wb_dat_o  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               in_ready <= 1'b1;
               if (in_fire) begin
                  if (in_data == OP_WR || in_data == OP_RD) begin
                     is_wr <= (in_data == OP_WR);
                     state <= S_ADRH;
                  end else begin
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_data  <= ST_BADOP;
                     state     <= S_STATUS;
                  end
               end
            end
            S_ADRH: begin
               if (in_fire) begin
                  wb_adr_o[15:8] <= in_data;
                  state          <= S_ADRL;
               end
            end
            S_ADRL: begin
               if (in_fire) begin
                  wb_adr_o[7:0] <= in_data;
                  state         <= S_CNT;
               end
            end
            S_CNT: begin
               if (in_fire) begin
                  cnt <= decode_cnt(in_data);
                  if (is_wr) begin
                     state <= S_WDATA;
                  end else begin
                     in_ready <= 1'b0;
                     wb_cyc_o <= 1'b1;
                     wb_stb_o <= 1'b1;
                     wb_we_o  <= 1'b0;
                     timer    <= '0;
                     state    <= S_RBUS;
                  end
               end
            end
            S_WDATA: begin
               if (in_fire) begin
                  wb_dat_o <= in_data;
                  in_ready <= 1'b0;
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  wb_we_o  <= 1'b1;
                  timer    <= '0;
                  state    <= S_WBUS;
               end
            end
            // Ack is tested before the timer so a last-cycle ack still succeeds.
            S_WBUS: begin
               if (bus_ack) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  wb_we_o  <= 1'b0;
                  wb_adr_o <= wb_adr_o + 16'd1;
                  cnt      <= cnt - 9'd1;
                  if (cnt == 9'd1) begin
                     out_valid <= 1'b1;
                     out_data  <= ST_OK;
                     state     <= S_STATUS;
                  end else begin
                     in_ready <= 1'b1;
                     state    <= S_WDATA;
                  end
               end else if (bus_tmo) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  wb_we_o  <= 1'b0;
                  cnt      <= cnt - 9'd1;
                  if (cnt == 9'd1) begin
                     out_valid <= 1'b1;
                     out_data  <= ST_TMO;
                     state     <= S_STATUS;
                  end else begin
                     in_ready <= 1'b1;
                     state    <= S_DRAIN;
                  end
               end else if (wb_stb_o) begin
                  timer <= timer + 16'd1;
               end
            end
            S_RBUS: begin
               if (bus_ack) begin
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  wb_adr_o  <= wb_adr_o + 16'd1;
                  cnt       <= cnt - 9'd1;
                  out_data  <= wb_dat_i;
                  out_valid <= 1'b1;
                  state     <= S_RSEND;
               end else if (bus_tmo) begin
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  out_valid <= 1'b1;
                  out_data  <= ST_TMO;
                  state     <= S_STATUS;
               end else if (wb_stb_o) begin
                  timer <= timer + 16'd1;
               end
            end
            S_RSEND: begin
               if (out_fire) begin
                  if (cnt != 9'd0) begin
                     out_valid <= 1'b0;
                     wb_cyc_o  <= 1'b1;
                     wb_stb_o  <= 1'b1;
                     timer     <= '0;
                     state     <= S_RBUS;
                  end else begin
                     out_data <= ST_OK;
                     state    <= S_STATUS;
                  end
               end
            end
            // Swallow the rest of an aborted write so the host stays frame-aligned.
            S_DRAIN: begin
               if (in_fire) begin
                  cnt <= cnt - 9'd1;
                  if (cnt == 9'd1) begin
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_data  <= ST_TMO;
                     state     <= S_STATUS;
                  end
               end
            end
            S_STATUS: begin
               if (out_fire) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed frame table, corner-case sequences and random frames
// checked against a frame-level model of the command protocol.
module tb_wb_cmd_master;

   localparam int TMO = 8;

   logic        clk;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [15:0] wb_adr_o;
   logic [7:0]  wb_dat_o;
   logic [7:0]  wb_dat_i;
   logic        wb_ack_i;

   wb_cmd_master #(.TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .wb_cyc_o  (wb_cyc_o),
      .wb_stb_o  (wb_stb_o),
      .wb_we_o   (wb_we_o),
      .wb_adr_o  (wb_adr_o),
      .wb_dat_o  (wb_dat_o),
      .wb_dat_i  (wb_dat_i),
      .wb_ack_i  (wb_ack_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        we;
      logic [15:0] adr;
      logic [7:0]  dat;
   } bus_t;

   typedef struct {
      logic [7:0]  op;
      logic [15:0] adr;
      logic [7:0]  cnt;
      logic [31:0] wd;
      int          dly;
      bit          nak;
      logic [7:0]  exp_st;
      int          exp_nbus;
   } vec_t;

   int         total = 0;
   int         bad = 0;
   bus_t       bus_log[$];
   logic [7:0] out_q[$];
   int         stb_total = 0;
   int         ack_delay = 0;
   bit         no_ack = 1'b0;
   int         wait_cnt = 0;
   logic [7:0] mem [int];
   logic [7:0] ref_mem [int];

   function automatic logic [7:0] init_val(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [15:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
   endfunction

   // Wishbone target: acks after ack_delay wait cycles, or never when no_ack is set.
   always @(negedge clk) begin
      if (!rst_n) begin
         wb_ack_i = 1'b0;
         wb_dat_i = 8'h00;
         wait_cnt = 0;
      end else begin
         if (wb_stb_o) stb_total++;
         if (wb_ack_i) begin
            wb_ack_i = 1'b0;
            wait_cnt = 0;
         end else if (wb_cyc_o && wb_stb_o) begin
            if (!no_ack && wait_cnt >= ack_delay) begin
               wb_ack_i = 1'b1;
               if (wb_we_o) begin
                  mem[int'(wb_adr_o)] = wb_dat_o;
                  bus_log.push_back({1'b1, wb_adr_o, wb_dat_o});
               end else begin
                  wb_dat_i = mem.exists(int'(wb_adr_o)) ? mem[int'(wb_adr_o)] : init_val(wb_adr_o);
                  bus_log.push_back({1'b0, wb_adr_o, wb_dat_i});
               end
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) out_q.push_back(out_data);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bit done;
      done     = 1'b0;
      in_data  = b;
      in_valid = 1'b1;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL send_timeout: byte %0h not accepted", b);
      end
   endtask

   task automatic wait_out(input int want);
      int i;
      i = 0;
      while (out_q.size() < want && i < 5000) begin
         tick(1);
         i++;
      end
      if (out_q.size() < want) begin
         total++;
         bad++;
         $display("FAIL out_timeout: got %0d bytes want %0d", out_q.size(), want);
      end
   endtask

   task automatic run_frame(input logic [7:0] op, input logic [15:0] adr, input logic [7:0] cnt,
                            input logic [7:0] data[$], input int dly, input bit nak,
                            output logic [7:0] act_st, output int act_nbus);
      bus_t        exp_log[$];
      logic [7:0]  exp_out[$];
      int          n;
      int          log0;
      int          out0;
      int          stb0;
      int          exp_stb;
      logic [15:0] a;
      n         = (cnt == 8'h00) ? 256 : int'(cnt);
      ack_delay = dly;
      no_ack    = nak;
      log0      = bus_log.size();
      out0      = out_q.size();
      stb0      = stb_total;
      if (op != 8'h01 && op != 8'h02) begin
         exp_out.push_back(8'h02);
         exp_stb = 0;
      end else if (nak) begin
         exp_out.push_back(8'h01);
         exp_stb = TMO;
      end else begin
         for (int i = 0; i < n; i++) begin
            a = adr + 16'(i);
            if (op == 8'h01) begin
               ref_mem[int'(a)] = data[i];
               exp_log.push_back({1'b1, a, data[i]});
            end else begin
               exp_log.push_back({1'b0, a, ref_rd(a)});
               exp_out.push_back(ref_rd(a));
            end
         end
         exp_out.push_back(8'h00);
         exp_stb = n * (dly + 1);
      end

      send(op);
      if (op == 8'h01 || op == 8'h02) begin
         send(adr[15:8]);
         send(adr[7:0]);
         send(cnt);
         if (op == 8'h01) begin
            for (int i = 0; i < n; i++) send(data[i]);
         end
      end
      wait_out(out0 + exp_out.size());
      tick(3);

      chk("cyc_idle", 32'(wb_cyc_o), 32'd0);
      chk("stb_idle", 32'(wb_stb_o), 32'd0);
      chk("bus_count", 32'(bus_log.size() - log0), 32'(exp_log.size()));
      for (int i = 0; i < exp_log.size() && log0 + i < bus_log.size(); i++)
         chk($sformatf("bus[%0d]", i), 32'(bus_log[log0 + i]), 32'(exp_log[i]));
      chk("out_count", 32'(out_q.size() - out0), 32'(exp_out.size()));
      for (int i = 0; i < exp_out.size() && out0 + i < out_q.size(); i++)
         chk($sformatf("out[%0d]", i), 32'(out_q[out0 + i]), 32'(exp_out[i]));
      chk("stb_cycles", 32'(stb_total - stb0), 32'(exp_stb));
      act_st   = (out_q.size() > out0) ? out_q[out_q.size() - 1] : 8'hEE;
      act_nbus = bus_log.size() - log0;
   endtask

   initial begin
      vec_t        tbl[12];
      logic [7:0]  d[$];
      logic [7:0]  st;
      int          nb;
      int          n;
      int          o0;
      int          guard;
      logic [31:0] w;
      logic [7:0]  op;
      logic [15:0] adr;
      logic [7:0]  cnt;
      int          dly;
      bit          nak;

      tbl[0]  = '{8'h01, 16'h8010, 8'h01, 32'hAA000000, 2, 1'b0, 8'h00, 1};
      tbl[1]  = '{8'h01, 16'h87FE, 8'h03, 32'h11223300, 1, 1'b0, 8'h00, 3};
      tbl[2]  = '{8'h02, 16'h87FE, 8'h03, 32'h00000000, 0, 1'b0, 8'h00, 3};
      tbl[3]  = '{8'h02, 16'h0000, 8'h02, 32'h00000000, 0, 1'b1, 8'h01, 0};
      tbl[4]  = '{8'h01, 16'h0000, 8'h03, 32'hA1A2A300, 0, 1'b1, 8'h01, 0};
      tbl[5]  = '{8'h01, 16'h4000, 8'h02, 32'h55660000, 1, 1'b0, 8'h00, 2};
      tbl[6]  = '{8'h00, 16'h0000, 8'h00, 32'h00000000, 0, 1'b0, 8'h02, 0};
      tbl[7]  = '{8'h01, 16'hFFFF, 8'h02, 32'hC33C0000, 0, 1'b0, 8'h00, 2};
      tbl[8]  = '{8'h02, 16'hFFFF, 8'h02, 32'h00000000, 3, 1'b0, 8'h00, 2};
      tbl[9]  = '{8'h02, 16'h1234, 8'h01, 32'h00000000, 7, 1'b0, 8'h00, 1};
      tbl[10] = '{8'h01, 16'h1234, 8'h01, 32'hEE000000, 0, 1'b1, 8'h01, 0};
      tbl[11] = '{8'h02, 16'hFF00, 8'h00, 32'h00000000, 0, 1'b0, 8'h00, 256};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      tick(3);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_cyc",       32'(wb_cyc_o),  32'd0);
      chk("rst_stb",       32'(wb_stb_o),  32'd0);
      chk("rst_we",        32'(wb_we_o),   32'd0);
      chk("rst_adr",       32'(wb_adr_o),  32'd0);
      chk("rst_dat",       32'(wb_dat_o),  32'd0);
      rst_n = 1'b1;
      tick(1);
      chk("idle_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 12; i++) begin
         n = (tbl[i].cnt == 8'h00) ? 256 : int'(tbl[i].cnt);
         d.delete();
         w = tbl[i].wd;
         for (int k = 0; k < n; k++) d.push_back((k < 4) ? w[31 - 8 * k -: 8] : 8'(k));
         run_frame(tbl[i].op, tbl[i].adr, tbl[i].cnt, d, tbl[i].dly, tbl[i].nak, st, nb);
         chk($sformatf("tbl%0d_status", i), 32'(st), 32'(tbl[i].exp_st));
         chk($sformatf("tbl%0d_nbus", i), 32'(nb), 32'(tbl[i].exp_nbus));
         if (i == 2 && out_q.size() >= 4) begin
            chk("burst_b0", 32'(out_q[out_q.size() - 4]), 32'h11);
            chk("burst_b1", 32'(out_q[out_q.size() - 3]), 32'h22);
            chk("burst_b2", 32'(out_q[out_q.size() - 2]), 32'h33);
         end
      end

      // Bad opcode held under backpressure.
      out_ready = 1'b0;
      o0 = out_q.size();
      send(8'h7F);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_data",  32'(out_data),  32'h02);
         chk("bp_in_ready",  32'(in_ready),  32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_out(o0 + 1);
      if (out_q.size() > o0) chk("bp_status", 32'(out_q[o0]), 32'h02);
      chk("bp_released", 32'(out_valid), 32'd0);

      // Reset asserted between clock edges while a read is on the bus.
      ack_delay = 0;
      no_ack    = 1'b1;
      send(8'h02);
      send(8'h12);
      send(8'h34);
      send(8'h02);
      guard = 0;
      while (!wb_stb_o && guard < 20) begin
         tick(1);
         guard++;
      end
      chk("mid_stb_up", 32'(wb_stb_o), 32'd1);
      tick(2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_cyc",       32'(wb_cyc_o),  32'd0);
      chk("async_stb",       32'(wb_stb_o),  32'd0);
      chk("async_out_valid", 32'(out_valid), 32'd0);
      tick(2);
      rst_n  = 1'b1;
      no_ack = 1'b0;
      tick(1);
      d.delete();
      d.push_back(8'h77);
      d.push_back(8'h88);
      run_frame(8'h01, 16'h2000, 8'h02, d, 0, 1'b0, st, nb);
      chk("post_rst_status", 32'(st), 32'h00);
      chk("post_rst_nbus", 32'(nb), 32'd2);

      for (int r = 0; r < 30; r++) begin
         n   = $urandom_range(0, 9);
         op  = (n < 5) ? 8'h01 : (n < 9) ? 8'h02 : 8'($urandom_range(3, 255));
         adr = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
         cnt = 8'($urandom_range(1, 6));
         nak = ($urandom_range(0, 7) == 0);
         dly = int'($urandom_range(0, 7));
         d.delete();
         for (int k = 0; k < int'(cnt); k++) d.push_back(8'($urandom));
         run_frame(op, adr, cnt, d, dly, nak, st, nb);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
